training_sequencer: RTL and testbench

Controller that sequences one training run of the neuron network: for each sample it issues a forward pass, waits for the result, issues a backward pass, waits for completion, then strobes a weight update. It repeats this for NS samples per epoch over NE epochs. It sits between the host/top-level start logic and the forward/backward handshake channels of the neuron layers. All network traffic is gated by this block's valid/ready handshakes.

---
 rtl/training_sequencer_if.sv | 50 +++++
 rtl/training_sequencer.sv | 170 +++++++++++++++++
 tb/tb_training_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/training_sequencer_if.sv
// -----------------------------------------------------------------------------
// training_sequencer_if
//
// Purpose: groups the four valid/ready channels between the training sequencer
// and the neuron layers. Signal names are seen from the sequencer side.
//
// Channels:
//   FS : forward issue       sequencer -> input layer   (oValid_FS / iReady_FS)
//   FR : forward result      output layer -> sequencer  (iValid_FR / oReady_FR)
//   BS : backward issue      sequencer -> layers        (oValid_BS / iReady_BS)
//   BR : backward completion layers -> sequencer        (iValid_BR / oReady_BR)
//
// Modports:
//   master : the sequencer
//   slave  : the network-side partner(s)
// -----------------------------------------------------------------------------
interface training_sequencer_if;

    logic oValid_FS;
    logic iReady_FS;
    logic iValid_FR;
    logic oReady_FR;
    logic oValid_BS;
    logic iReady_BS;
    logic iValid_BR;
    logic oReady_BR;

    modport master (
        output oValid_FS,
        input  iReady_FS,
        input  iValid_FR,
        output oReady_FR,
        output oValid_BS,
        input  iReady_BS,
        input  iValid_BR,
        output oReady_BR
    );

    modport slave (
        input  oValid_FS,
        output iReady_FS,
        output iValid_FR,
        input  oReady_FR,
        input  oValid_BS,
        output iReady_BS,
        output iValid_BR,
        input  oReady_BR
    );

endinterface

// File: rtl/training_sequencer.sv
// -----------------------------------------------------------------------------
// training_sequencer
//
// Purpose: sequences one training run. For every sample it issues a forward
// pass, waits for the forward result, issues a backward pass, waits for the
// backward completion and then strobes a weight update. NS samples make an
// epoch, NE epochs make a run.
//
// Parameters:
//   NS : samples per epoch (>= 1)
//   NE : epochs per run    (>= 1)
//   SW : sample-index width
//   EW : epoch-index width
//
// Ports:
//   iCLK    : clock, rising edge
//   iRST    : asynchronous active-high reset
//   iStart  : start request, only looked at while idle
//   oBusy   : high whenever the sequencer is not idle
//   oDone   : one-cycle pulse when the run completes
//   oUpdate : one-cycle weight-update strobe per sample
//   oSample : current sample index (holds its final value after a run)
//   oEpoch  : current epoch index  (holds its final value after a run)
//   bus     : forward/backward handshake channels (master side)
//
// All handshake and strobe outputs are pure decodes of the state register, so
// there is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module training_sequencer #(
    parameter int unsigned NS = 4,
    parameter int unsigned NE = 8,
    parameter int unsigned SW = (NS > 1) ? $clog2(NS) : 1,
    parameter int unsigned EW = (NE > 1) ? $clog2(NE) : 1
) (
    input  logic                        iCLK,
    input  logic                        iRST,
    input  logic                        iStart,
    output logic                        oBusy,
    output logic                        oDone,
    output logic                        oUpdate,
    output logic [SW-1:0]               oSample,
    output logic [EW-1:0]               oEpoch,
    training_sequencer_if.master        bus
);

    typedef enum logic [2:0] {
        StIdle,
        StFwdIssue,
        StFwdWait,
        StBwdIssue,
        StBwdWait,
        StUpdate,
        StDone
    } state_e;

    localparam logic [SW-1:0] SampleLast = SW'(NS - 1);
    localparam logic [EW-1:0] EpochLast  = EW'(NE - 1);

    state_e        stateQ, stateD;
    logic [SW-1:0] sampleQ, sampleD;
    logic [EW-1:0] epochQ, epochD;

    // -------------------------------------------------------------------------
    // State and counter registers
    // -------------------------------------------------------------------------
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            stateQ  <= StIdle;
            sampleQ <= '0;
            epochQ  <= '0;
        end else begin
            stateQ  <= stateD;
            sampleQ <= sampleD;
            epochQ  <= epochD;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and counter update
    // -------------------------------------------------------------------------
    always_comb begin
        stateD  = stateQ;
        sampleD = sampleQ;
        epochD  = epochQ;

        unique case (stateQ)
            StIdle: begin
                if (iStart) begin
                    sampleD = '0;
                    epochD  = '0;
                    stateD  = StFwdIssue;
                end
            end

            StFwdIssue: begin
                if (bus.iReady_FS) begin
                    stateD = StFwdWait;
                end
            end

            StFwdWait: begin
                if (bus.iValid_FR) begin
                    stateD = StBwdIssue;
                end
            end

            StBwdIssue: begin
                if (bus.iReady_BS) begin
                    stateD = StBwdWait;
                end
            end

            StBwdWait: begin
                if (bus.iValid_BR) begin
                    stateD = StUpdate;
                end
            end

            StUpdate: begin
                if (sampleQ != SampleLast) begin
                    sampleD = sampleQ + 1'b1;
                    stateD  = StFwdIssue;
                end else if (epochQ != EpochLast) begin
                    sampleD = '0;
                    epochD  = epochQ + 1'b1;
                    stateD  = StFwdIssue;
                end else begin
                    // Last sample of last epoch: counters keep their final values.
                    stateD = StDone;
                end
            end

            StDone: begin
                stateD = StIdle;
            end

            default: begin
                stateD = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode (state only)
    // -------------------------------------------------------------------------
    always_comb begin
        oBusy         = 1'b1;
        oDone         = 1'b0;
        oUpdate       = 1'b0;
        bus.oValid_FS = 1'b0;
        bus.oReady_FR = 1'b0;
        bus.oValid_BS = 1'b0;
        bus.oReady_BR = 1'b0;

        unique case (stateQ)
            StIdle:     oBusy         = 1'b0;
            StFwdIssue: bus.oValid_FS = 1'b1;
            StFwdWait:  bus.oReady_FR = 1'b1;
            StBwdIssue: bus.oValid_BS = 1'b1;
            StBwdWait:  bus.oReady_BR = 1'b1;
            StUpdate:   oUpdate       = 1'b1;
            StDone:     oDone         = 1'b1;
            default:    oBusy         = 1'b0;
        endcase
    end

    assign oSample = sampleQ;
    assign oEpoch  = epochQ;

endmodule

// File: tb/tb_training_sequencer.sv
// -----------------------------------------------------------------------------
// tb_training_sequencer
//
// Directed bench for training_sequencer. Three instances:
//   dutA : NS=4, NE=2 (full run, backpressure, stray inputs, back-to-back)
//   dutB : NS=1, NE=1 (smallest run)
//   dutC : NS=4, NE=8 (mid-run asynchronous reset at sample 2, epoch 3)
// Status vectors are packed {busy, done, validFS, readyFR, validBS, readyBR, update}.
// -----------------------------------------------------------------------------
module tb_training_sequencer;

    localparam logic [6:0] StsIdle = 7'b0000000;
    localparam logic [6:0] StsFI   = 7'b1010000;
    localparam logic [6:0] StsFW   = 7'b1001000;
    localparam logic [6:0] StsBI   = 7'b1000100;
    localparam logic [6:0] StsBW   = 7'b1000010;
    localparam logic [6:0] StsUp   = 7'b1000001;
    localparam logic [6:0] StsDone = 7'b1100000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned nVec  = 0;
    int unsigned nMiss = 0;

    // DUT A
    logic       startA, busyA, doneA, updA;
    logic [1:0] sampleA;
    logic       epochA;
    training_sequencer_if ifA ();

    training_sequencer #(.NS(4), .NE(2)) dutA (
        .iCLK    (clk),
        .iRST    (rst),
        .iStart  (startA),
        .oBusy   (busyA),
        .oDone   (doneA),
        .oUpdate (updA),
        .oSample (sampleA),
        .oEpoch  (epochA),
        .bus     (ifA.master)
    );

    // DUT B
    logic startB, busyB, doneB, updB;
    logic sampleB;
    logic epochB;
    training_sequencer_if ifB ();

    training_sequencer #(.NS(1), .NE(1)) dutB (
        .iCLK    (clk),
        .iRST    (rst),
        .iStart  (startB),
        .oBusy   (busyB),
        .oDone   (doneB),
        .oUpdate (updB),
        .oSample (sampleB),
        .oEpoch  (epochB),
        .bus     (ifB.master)
    );

    // DUT C
    logic       startC, busyC, doneC, updC;
    logic [1:0] sampleC;
    logic [2:0] epochC;
    training_sequencer_if ifC ();

    training_sequencer #(.NS(4), .NE(8)) dutC (
        .iCLK    (clk),
        .iRST    (rst),
        .iStart  (startC),
        .oBusy   (busyC),
        .oDone   (doneC),
        .oUpdate (updC),
        .oSample (sampleC),
        .oEpoch  (epochC),
        .bus     (ifC.master)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        if (obs !== exp) begin
            nMiss++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] stsA();
        return {busyA, doneA, ifA.oValid_FS, ifA.oReady_FR, ifA.oValid_BS, ifA.oReady_BR, updA};
    endfunction

    function automatic logic [6:0] stsB();
        return {busyB, doneB, ifB.oValid_FS, ifB.oReady_FR, ifB.oValid_BS, ifB.oReady_BR, updB};
    endfunction

    function automatic logic [6:0] stsC();
        return {busyC, doneC, ifC.oValid_FS, ifC.oReady_FR, ifC.oValid_BS, ifC.oReady_BR, updC};
    endfunction

    // Expected status for phase p of a sample (0 = forward issue ... 4 = update).
    function automatic logic [6:0] phaseSts(input int p);
        case (p)
            0:       return StsFI;
            1:       return StsFW;
            2:       return StsBI;
            3:       return StsBW;
            default: return StsUp;
        endcase
    endfunction

    initial begin
        logic [6:0] eSts;
        int         eSam;
        int         eEp;
        int         updates;
        int         doneCyc;
        logic       found;

        startA = 1'b0;
        startB = 1'b0;
        startC = 1'b0;
        ifA.iReady_FS = 1'b1; ifA.iValid_FR = 1'b1; ifA.iReady_BS = 1'b1; ifA.iValid_BR = 1'b1;
        ifB.iReady_FS = 1'b1; ifB.iValid_FR = 1'b1; ifB.iReady_BS = 1'b1; ifB.iValid_BR = 1'b1;
        ifC.iReady_FS = 1'b1; ifC.iValid_FR = 1'b1; ifC.iReady_BS = 1'b1; ifC.iValid_BR = 1'b1;

        // ---------------- reset values ----------------
        rst = 1'b1;
        tick();
        tick();
        checkVal("rst.stsA", 32'(stsA()), 32'(StsIdle));
        checkVal("rst.sampleA", 32'(sampleA), 32'd0);
        checkVal("rst.epochA", 32'(epochA), 32'd0);
        checkVal("rst.stsB", 32'(stsB()), 32'(StsIdle));
        checkVal("rst.stsC", 32'(stsC()), 32'(StsIdle));
        rst = 1'b0;
        tick();
        checkVal("idle.stsA", 32'(stsA()), 32'(StsIdle));

        // ---------------- mid-run async reset on C (sample 2, epoch 3) ----------------
        startC = 1'b1;
        tick();
        startC = 1'b0;
        // Cycle 1 is the first forward issue; sample 14 (= epoch 3, sample 2)
        // reaches its backward-wait phase in cycle 14*5+4 = 74.
        for (int n = 1; n < 74; n++) tick();
        checkVal("midC.sts", 32'(stsC()), 32'(StsBW));
        checkVal("midC.sample", 32'(sampleC), 32'd2);
        checkVal("midC.epoch", 32'(epochC), 32'd3);
        #2 rst = 1'b1;
        #1;
        checkVal("asyncRst.sts", 32'(stsC()), 32'(StsIdle));
        checkVal("asyncRst.sample", 32'(sampleC), 32'd0);
        checkVal("asyncRst.epoch", 32'(epochC), 32'd0);
        #2 rst = 1'b0;
        tick();
        tick();
        tick();
        checkVal("postRst.stsC", 32'(stsC()), 32'(StsIdle));

        // ---------------- full run on A, always-ready partners ----------------
        startA = 1'b1;
        tick();
        startA = 1'b0;
        updates = 0;
        doneCyc = 0;
        for (int n = 1; n <= 42; n++) begin
            if (n <= 40) begin
                eSts = phaseSts((n - 1) % 5);
                eSam = ((n - 1) / 5) % 4;
                eEp  = ((n - 1) / 5) / 4;
            end else if (n == 41) begin
                eSts = StsDone;
                eSam = 3;
                eEp  = 1;
            end else begin
                eSts = StsIdle;
                eSam = 3;
                eEp  = 1;
            end
            checkVal($sformatf("run.sts[%0d]", n), 32'(stsA()), 32'(eSts));
            checkVal($sformatf("run.sample[%0d]", n), 32'(sampleA), 32'(eSam));
            checkVal($sformatf("run.epoch[%0d]", n), 32'(epochA), 32'(eEp));
            if (updA) updates++;
            if (doneA && doneCyc == 0) doneCyc = n;
            tick();
        end
        checkVal("run.updates", 32'(updates), 32'd8);
        checkVal("run.doneCycle", 32'(doneCyc), 32'd41);

        // ---------------- backpressure on forward issue ----------------
        ifA.iReady_FS = 1'b0;
        startA = 1'b1;
        tick();
        startA = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            checkVal($sformatf("bp.sts[%0d]", i), 32'(stsA()), 32'(StsFI));
            checkVal($sformatf("bp.sample[%0d]", i), 32'(sampleA), 32'd0);
            tick();
        end
        ifA.iReady_FS = 1'b1;
        checkVal("bp.sts[8]", 32'(stsA()), 32'(StsFI));
        tick();
        checkVal("bp.afterXfer", 32'(stsA()), 32'(StsFW));

        // ---------------- stray inputs ----------------
        ifA.iValid_FR = 1'b0;
        ifA.iValid_BR = 1'b1;
        tick();
        checkVal("stray.brInFw", 32'(stsA()), 32'(StsFW));
        ifA.iValid_FR = 1'b1;
        ifA.iValid_BR = 1'b0;
        tick();
        checkVal("stray.toBi", 32'(stsA()), 32'(StsBI));
        ifA.iReady_BS = 1'b0;
        startA = 1'b1;
        tick();
        checkVal("stray.startInBi", 32'(stsA()), 32'(StsBI));
        checkVal("stray.sample", 32'(sampleA), 32'd0);
        checkVal("stray.epoch", 32'(epochA), 32'd0);
        startA = 1'b0;
        ifA.iReady_BS = 1'b1;
        tick();
        checkVal("stray.toBw", 32'(stsA()), 32'(StsBW));
        tick();
        checkVal("stray.bwHold", 32'(stsA()), 32'(StsBW));
        ifA.iValid_BR = 1'b1;
        tick();
        checkVal("stray.toUpd", 32'(stsA()), 32'(StsUp));
        tick();
        checkVal("stray.nextFi", 32'(stsA()), 32'(StsFI));
        checkVal("stray.nextSample", 32'(sampleA), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // ---------------- NS=1, NE=1 ----------------
        startB = 1'b1;
        tick();
        startB = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            if (n <= 5)      eSts = phaseSts(n - 1);
            else if (n == 6) eSts = StsDone;
            else             eSts = StsIdle;
            checkVal($sformatf("one.sts[%0d]", n), 32'(stsB()), 32'(eSts));
            checkVal($sformatf("one.sample[%0d]", n), 32'(sampleB), 32'd0);
            checkVal($sformatf("one.epoch[%0d]", n), 32'(epochB), 32'd0);
            tick();
        end

        // ---------------- back-to-back runs on A ----------------
        startA = 1'b1;
        tick();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (doneA) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checkVal("b2b.doneSeen", 32'(found), 32'd1);
        checkVal("b2b.doneSample", 32'(sampleA), 32'd3);
        checkVal("b2b.doneEpoch", 32'(epochA), 32'd1);
        tick();
        checkVal("b2b.idleGap", 32'(stsA()), 32'(StsIdle));
        tick();
        checkVal("b2b.restart", 32'(stsA()), 32'(StsFI));
        checkVal("b2b.sample", 32'(sampleA), 32'd0);
        checkVal("b2b.epoch", 32'(epochA), 32'd0);
        startA = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
